// File: rtl/hdc_train_scheduler.sv
// rtl/hdc_train_scheduler.sv - round-robin sample scheduler for the chunked HDC class-accumulation engine
module hdc_train_scheduler #(
    parameter int HV_W        = 50,
    parameter int CLASS_W     = 5,
    parameter int NUM_CLASSES = 26,
    parameter int NUM_CHUNKS  = 10,
    parameter int TO_MARGIN   = 4,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               req0_valid,
    input  logic [HV_W-1:0]    req0_hv,
    input  logic [CLASS_W-1:0] req0_class,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [HV_W-1:0]    req1_hv,
    input  logic [CLASS_W-1:0] req1_class,
    output logic               req1_ready,
    output logic               eng_input_ready,
    output logic [HV_W-1:0]    eng_hv,
    output logic [CLASS_W-1:0] eng_class,
    input  logic               eng_accept_en,
    input  logic               flush,
    output logic               busy,
    output logic               timeout_err,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [CNT_W-1:0]   total_cnt,
    input  logic [CLASS_W-1:0] cnt_rd_class,
    output logic [CNT_W-1:0]   cnt_rd_data
);

    localparam int TO_LIMIT = NUM_CHUNKS + TO_MARGIN;
    localparam int WAIT_W   = $clog2(TO_LIMIT + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST   = WAIT_W'(TO_LIMIT - 1);
    localparam logic [CLASS_W:0]   CLASS_LIMIT = (CLASS_W + 1)'(NUM_CLASSES);
    localparam logic [CLASS_W-1:0] NO_CLASS    = '1;
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t             state;
    state_t             state_next;
    logic               last_grant;
    logic               flush_pend;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   class_cnt [NUM_CLASSES];

    logic               grant_sel;
    logic [HV_W-1:0]    grant_hv;
    logic [CLASS_W-1:0] grant_class;
    logic               xfer;
    logic               xfer_legal;
    logic               do_flush;
    logic               done_ok;
    logic               done_to;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A pending or fresh flush owns the IDLE cycle, so no grant is offered then.
    always_comb begin
        state_next  = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        xfer        = 1'b0;
        xfer_legal  = 1'b0;
        do_flush    = 1'b0;
        done_ok     = 1'b0;
        done_to     = 1'b0;
        grant_sel   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        grant_hv    = grant_sel ? req1_hv : req0_hv;
        grant_class = grant_sel ? req1_class : req0_class;
        case (state)
            IDLE: begin
                if (flush || flush_pend) begin
                    do_flush = 1'b1;
                end else if (req0_valid || req1_valid) begin
                    req0_ready = ~grant_sel;
                    req1_ready = grant_sel;
                    xfer       = 1'b1;
                    if ({1'b0, grant_class} < CLASS_LIMIT) begin
                        xfer_legal = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (eng_accept_en) begin
                    done_ok    = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    done_to    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            last_grant  <= 1'b1;
            flush_pend  <= 1'b0;
            wait_cnt    <= '0;
            eng_hv      <= '0;
            eng_class   <= NO_CLASS;
            timeout_err <= 1'b0;
            drop_cnt    <= '0;
            total_cnt   <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                class_cnt[i] <= '0;
            end
        end else begin
            if (xfer) begin
                last_grant <= grant_sel;
                eng_hv     <= grant_hv;
                eng_class  <= xfer_legal ? grant_class : NO_CLASS;
                if (!xfer_legal && drop_cnt != CNT_MAX) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (done_ok) begin
                if (class_cnt[eng_class] != CNT_MAX) begin
                    class_cnt[eng_class] <= class_cnt[eng_class] + 1'b1;
                end
                if (total_cnt != CNT_MAX) begin
                    total_cnt <= total_cnt + 1'b1;
                end
                eng_class <= NO_CLASS;
            end
            if (done_to) begin
                timeout_err <= 1'b1;
                eng_class   <= NO_CLASS;
            end
            if (flush && state != IDLE) begin
                flush_pend <= 1'b1;
            end
            if (do_flush) begin
                flush_pend  <= 1'b0;
                timeout_err <= 1'b0;
                drop_cnt    <= '0;
                total_cnt   <= '0;
                for (int i = 0; i < NUM_CLASSES; i++) begin
                    class_cnt[i] <= '0;
                end
            end
        end
    end

    assign eng_input_ready = (state == ISSUE);
    assign busy            = (state != IDLE);

    always_comb begin
        cnt_rd_data = '0;
        if ({1'b0, cnt_rd_class} < CLASS_LIMIT) begin
            cnt_rd_data = class_cnt[cnt_rd_class];
        end
    end

endmodule

// File: tb/tb_hdc_train_scheduler.sv
// tb/tb_hdc_train_scheduler.sv - scoreboard bench for hdc_train_scheduler
module tb_hdc_train_scheduler;

    localparam int HV_W        = 50;
    localparam int CLASS_W     = 5;
    localparam int NUM_CLASSES = 26;
    localparam int NUM_CHUNKS  = 10;
    localparam int TO_MARGIN   = 4;
    localparam int CNT_W       = 8;

    logic               clk = 1'b0;
    logic               nrst = 1'b1;
    logic               req0_valid, req1_valid, req0_ready, req1_ready;
    logic [HV_W-1:0]    req0_hv, req1_hv, eng_hv;
    logic [CLASS_W-1:0] req0_class, req1_class, eng_class, cnt_rd_class;
    logic               eng_input_ready, eng_accept_en, flush, busy, timeout_err;
    logic [CNT_W-1:0]   drop_cnt, total_cnt, cnt_rd_data;

    hdc_train_scheduler #(
        .HV_W(HV_W), .CLASS_W(CLASS_W), .NUM_CLASSES(NUM_CLASSES),
        .NUM_CHUNKS(NUM_CHUNKS), .TO_MARGIN(TO_MARGIN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .nrst(nrst),
        .req0_valid(req0_valid), .req0_hv(req0_hv), .req0_class(req0_class), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_hv(req1_hv), .req1_class(req1_class), .req1_ready(req1_ready),
        .eng_input_ready(eng_input_ready), .eng_hv(eng_hv), .eng_class(eng_class),
        .eng_accept_en(eng_accept_en), .flush(flush), .busy(busy), .timeout_err(timeout_err),
        .drop_cnt(drop_cnt), .total_cnt(total_cnt),
        .cnt_rd_class(cnt_rd_class), .cnt_rd_data(cnt_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [HV_W-1:0]    hv;
        logic [CLASS_W-1:0] cls;
    } sample_t;

    sample_t q0[$], q1[$], exp_q[$], eng_q[$];
    int m_cnt [NUM_CLASSES];
    int m_total, m_drop, m_to, m_last;
    int checks = 0;
    int errors = 0;
    bit hang = 0, spur_req = 0, abort = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void clear_model();
        for (int i = 0; i < NUM_CLASSES; i++) m_cnt[i] = 0;
        m_total = 0;
        m_drop  = 0;
        m_to    = 0;
    endfunction

    function automatic void accept_sample(input sample_t s);
        if (int'(s.cls) >= NUM_CLASSES) begin
            if (m_drop < 255) m_drop++;
        end else begin
            exp_q.push_back(s);
            eng_q.push_back(s);
        end
    endfunction

    // Scoreboard monitor: every engine start must match the next accepted legal sample.
    initial begin : monitor
        sample_t e;
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_input_ready) begin
                check("pulse_one_cycle", prev, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue actual=pulse expected=none");
                end else begin
                    e = exp_q.pop_front();
                    check("issue_hv", eng_hv, e.hv);
                    check("issue_class", eng_class, e.cls);
                end
            end
            prev = eng_input_ready;
        end
    end

    // Engine model: completes NUM_CHUNKS cycles after the start pulse unless told to hang.
    initial begin : engine
        sample_t s;
        eng_accept_en = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_input_ready && !abort) begin
                s = (eng_q.size() > 0) ? eng_q.pop_front() : '{default: '0};
                if (!hang) begin
                    repeat (NUM_CHUNKS) @(posedge clk);
                    #1;
                    if (!abort) begin
                        eng_accept_en = 1'b1;
                        check("hold_hv", eng_hv, s.hv);
                        check("hold_class", eng_class, s.cls);
                        if (m_cnt[s.cls] < 255) m_cnt[s.cls]++;
                        if (m_total < 255) m_total++;
                        @(posedge clk);
                        #1;
                        eng_accept_en = 1'b0;
                    end
                end
            end else if (spur_req) begin
                @(posedge clk);
                #1;
                eng_accept_en = 1'b1;
                @(posedge clk);
                #1;
                eng_accept_en = 1'b0;
                spur_req = 0;
            end
        end
    end

    task automatic pump(input int budget);
        int cyc;
        int g;
        sample_t s;
        cyc = 0;
        while ((q0.size() + q1.size()) > 0 && cyc < budget) begin
            @(posedge clk);
            #1;
            req0_valid = (q0.size() > 0);
            req1_valid = (q1.size() > 0);
            if (req0_valid) begin req0_hv = q0[0].hv; req0_class = q0[0].cls; end
            if (req1_valid) begin req1_hv = q1[0].hv; req1_class = q1[0].cls; end
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
                else g = req1_valid ? 1 : 0;
                check("grant_one_hot", req0_ready & req1_ready, 0);
                check("grant_sel", req1_ready, g);
                m_last = g;
                s = (g == 1) ? q1.pop_front() : q0.pop_front();
                accept_sample(s);
            end
            cyc++;
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("pump_budget", q0.size() + q1.size(), 0);
    endtask

    task automatic wait_idle(input int budget);
        int b;
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (busy && b < budget);
        check("wait_idle", busy, 0);
    endtask

    task automatic check_counts(input string tag);
        for (int c = 0; c < 32; c++) begin
            cnt_rd_class = CLASS_W'(c);
            #1;
            check($sformatf("%s_cnt%0d", tag, c), cnt_rd_data, (c < NUM_CLASSES) ? m_cnt[c] : 0);
        end
        check({tag, "_total"}, total_cnt, m_total);
        check({tag, "_drop"}, drop_cnt, m_drop);
        check({tag, "_timeout"}, timeout_err, m_to);
        check({tag, "_idle_class"}, eng_class, 5'h1f);
    endtask

    function automatic sample_t mk(input int cls);
        sample_t s;
        s.hv  = HV_W'({$urandom(), $urandom()});
        s.cls = CLASS_W'(cls);
        return s;
    endfunction

    initial begin : main
        int b;
        req0_valid = 0; req1_valid = 0; req0_hv = '0; req1_hv = '0;
        req0_class = '0; req1_class = '0; flush = 0; cnt_rd_class = '0;
        clear_model();
        m_last = 1;
        #1 nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_eng_class", eng_class, 5'h1f);
        check("rst_eng_hv", eng_hv, 0);
        check("rst_pulse", eng_input_ready, 0);
        check("rst_total", total_cnt, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_timeout", timeout_err, 0);
        nrst = 1'b1;

        // single nominal sample with cycle-exact completion
        q0.push_back('{50'h1, 5'd3});
        pump(20);
        @(negedge clk);
        check("t1_pulse", eng_input_ready, 1);
        repeat (NUM_CHUNKS) @(negedge clk);
        check("t1_busy_at_accept", busy, 1);
        check("t1_accept", eng_accept_en, 1);
        @(negedge clk);
        check("t1_idle", busy, 0);
        check_counts("t1");

        // both requesters contending
        q0.push_back(mk(1)); q0.push_back(mk(2));
        q1.push_back(mk(4)); q1.push_back(mk(6));
        pump(200);
        wait_idle(40);
        check_counts("arb");

        // illegal class is dropped without starting the engine
        q1.push_back(mk(30));
        pump(10);
        @(negedge clk);
        check("drop_busy", busy, 0);
        check("drop_pulse", eng_input_ready, 0);
        check_counts("drop");

        // hung engine: timeout after 14 WAIT cycles
        hang = 1;
        q0.push_back(mk(9));
        pump(20);
        b = 0;
        do begin @(negedge clk); b++; end while (!eng_input_ready && b < 5);
        check("to_pulse_seen", eng_input_ready, 1);
        repeat (NUM_CHUNKS + TO_MARGIN) @(negedge clk);
        check("to_still_busy", busy, 1);
        check("to_not_yet", timeout_err, 0);
        @(negedge clk);
        check("to_idle", busy, 0);
        check("to_flag", timeout_err, 1);
        m_to = 1;
        hang = 0;
        q0.push_back(mk(9));
        pump(20);
        wait_idle(40);
        check_counts("to_next");

        // spurious completion in IDLE is ignored
        spur_req = 1;
        b = 0;
        while (spur_req && b < 20) begin @(negedge clk); b++; end
        check("spur_done", spur_req, 0);
        check_counts("spur");

        // randomized traffic across both requesters
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1) q1.push_back(mk($urandom_range(0, 31)));
            else q0.push_back(mk($urandom_range(0, 31)));
        end
        pump(24 * 20);
        wait_idle(40);
        check_counts("rand");

        // flush in IDLE blocks transfers that cycle and clears everything
        @(posedge clk);
        #1;
        flush = 1'b1;
        req0_valid = 1'b1;
        req0_class = 5'd5;
        #1;
        check("flush_ready0", req0_ready, 0);
        check("flush_ready1", req1_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        req0_valid = 1'b0;
        clear_model();
        @(negedge clk);
        check("flush_busy", busy, 0);
        check_counts("flush_idle");

        // flush during WAIT lands after the completing sample's increment
        q0.push_back(mk(5)); q0.push_back(mk(5));
        pump(60);
        wait_idle(40);
        check_counts("pre_flush");
        q0.push_back(mk(5));
        pump(20);
        repeat (3) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wait_idle(40);
        @(negedge clk);
        clear_model();
        check_counts("flush_wait");

        // saturation of class and total counters
        for (int i = 0; i < 300; i++) q0.push_back(mk(7));
        pump(300 * 15);
        wait_idle(40);
        check("sat_model", m_cnt[7], 255);
        check_counts("sat");

        // asynchronous reset mid-WAIT
        q0.push_back(mk(2));
        pump(20);
        repeat (3) @(posedge clk);
        #1;
        check("mid_wait_busy", busy, 1);
        abort = 1;
        nrst = 1'b0;
        cnt_rd_class = 5'd7;
        #1;
        check("arst_busy", busy, 0);
        check("arst_eng_class", eng_class, 5'h1f);
        check("arst_eng_hv", eng_hv, 0);
        check("arst_total", total_cnt, 0);
        check("arst_drop", drop_cnt, 0);
        check("arst_timeout", timeout_err, 0);
        check("arst_cnt7", cnt_rd_data, 0);
        check("arst_pulse", eng_input_ready, 0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_total", total_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
